// File: rtl/draw_scheduler_if.sv
// Bus between the sprite drawers / frame controller and the draw scheduler.
// The master side owns the drawer request/pixel signals and the frame tick;
// the slave side (the scheduler) owns the grant, the adapter pixel port and status.
interface draw_scheduler_if #(
   parameter int NUM_REQ = 6,
   parameter int COLOR_W = 12
);
   logic                       frame_tick;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ-1:0]         done;
   logic [NUM_REQ-1:0]         key_en;
   logic [9*NUM_REQ-1:0]       px_x;
   logic [8*NUM_REQ-1:0]       px_y;
   logic [COLOR_W*NUM_REQ-1:0] px_color;
   logic [NUM_REQ-1:0]         px_we;

   logic [NUM_REQ-1:0]         grant;
   logic [8:0]                 X_out;
   logic [7:0]                 Y_out;
   logic [COLOR_W-1:0]         Color_out;
   logic                       writeEn;
   logic                       busy;
   logic                       frame_done;
   logic                       overrun;
   logic                       timeout_err;

   modport master (
      output frame_tick, req, done, key_en, px_x, px_y, px_color, px_we,
      input  grant, X_out, Y_out, Color_out, writeEn, busy, frame_done, overrun, timeout_err
   );

   modport slave (
      input  frame_tick, req, done, key_en, px_x, px_y, px_color, px_we,
      output grant, X_out, Y_out, Color_out, writeEn, busy, frame_done, overrun, timeout_err
   );
endinterface

// File: rtl/draw_scheduler.sv
// Frame-level scheduler for the single VGA pixel-write port. Each frame pass
// walks the drawers in index order, grants each requesting drawer until it
// signals done (or the watchdog fires) and forwards its pixels through one
// register stage, dropping colour-key pixels for transparent drawers.
module draw_scheduler #(
   parameter int                 NUM_REQ     = 6,
   parameter int                 COLOR_W     = 12,
   parameter logic [COLOR_W-1:0] KEY_COLOR   = '0,
   parameter int                 TIMEOUT_CYC = 131072
) (
   input logic             clk,
   input logic             reset,
   draw_scheduler_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_GRANT  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic               timeout_q, timeout_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;

   logic [8:0]         x_q;
   logic [7:0]         y_q;
   logic [COLOR_W-1:0] color_q;
   logic               we_q;

   logic               last_idx;
   logic               wd_expired;
   int                 sel;
   logic [8:0]         sel_x;
   logic [7:0]         sel_y;
   logic [COLOR_W-1:0] sel_color;

   assign last_idx   = (idx_q == IDX_W'(NUM_REQ - 1));
   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));

   assign sel       = int'(idx_q);
   assign sel_x     = bus.px_x[sel*9 +: 9];
   assign sel_y     = bus.px_y[sel*8 +: 8];
   assign sel_color = bus.px_color[sel*COLOR_W +: COLOR_W];

   // Next-state logic: pass sequencing, frame-tick queueing and sticky error flags.
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it unassigned; otherwise synthesis infers a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (bus.frame_tick || pending_q) begin
               state_d = S_SCAN;
               idx_d   = '0;
            end
         end
         S_SCAN: begin
            if (bus.req[idx_q])  state_d = S_GRANT;
            else if (last_idx)   state_d = S_FINISH;
            else                 idx_d   = idx_q + IDX_W'(1);
         end
         S_GRANT: begin
            if (bus.done[idx_q] || wd_expired) begin
               if (!bus.done[idx_q]) timeout_d = 1'b1;
               if (last_idx) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_SCAN;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A tick seen in IDLE starts the pass directly; otherwise it is queued one deep.
      if (state_q == S_IDLE) begin
         pending_d = 1'b0;
      end else if (bus.frame_tick) begin
         if (pending_q) overrun_d = 1'b1;
         else           pending_d = 1'b1;
      end

      // Watchdog restarts on every state entry and only advances while a grant is held.
      wd_d = (state_q == S_GRANT && state_d == S_GRANT) ? wd_q + WD_W'(1) : '0;

      grant_d      = (state_d == S_GRANT) ? (NUM_REQ'(1) << idx_d) : '0;
      busy_d       = (state_d == S_SCAN) || (state_d == S_GRANT);
      frame_done_d = (state_d == S_FINISH);
   end

   // Control and status registers; reset wins over every input, even mid-pass.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
         wd_q         <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
         wd_q         <= wd_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Pixel stage: forward the granted drawer's pixel one cycle later; coordinates hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
         we_q    <= 1'b0;
      end else if (state_q == S_GRANT) begin
         x_q     <= sel_x;
         y_q     <= sel_y;
         color_q <= sel_color;
         we_q    <= bus.px_we[idx_q] & ~(bus.key_en[idx_q] & (sel_color == KEY_COLOR));
      end else begin
         we_q    <= 1'b0;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.overrun     = overrun_q;
   assign bus.timeout_err = timeout_q;
   assign bus.X_out       = x_q;
   assign bus.Y_out       = y_q;
   assign bus.Color_out   = color_q;
   assign bus.writeEn     = we_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: reactive drawer models feed random
// pixels, a scoreboard predicts forwarded writes, grant order/lengths and pass
// lengths from the scheduling rules, and a monitor compares against the DUT.
`timescale 1ns/1ps
module tb_draw_scheduler;
   localparam int N  = 6;
   localparam int CW = 12;
   localparam int TO = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   draw_scheduler_if #(.NUM_REQ(N), .COLOR_W(CW)) bus ();

   draw_scheduler #(
      .NUM_REQ(N), .COLOR_W(CW), .KEY_COLOR(12'h000), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [11:0] c;
      int          t;
   } px_t;

   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   int  fd_cnt = 0;

   px_t pxq[$];   // expected adapter writes, in order
   int  ordq[$];  // expected grant order across queued passes
   int  lenq[$];  // expected busy cycles per pass

   int  cfg_len[N];
   bit  cfg_hang[N];
   bit  dir_mode = 1'b0;
   int  gcyc[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_glen(input int i);
      return cfg_hang[i] ? TO : cfg_len[i];
   endfunction

   // Reference: grants go to requesting drawers in index order; every slot costs
   // one scan cycle plus the grant duration of a requesting drawer.
   task automatic push_pass();
      int plen = 0;
      for (int i = 0; i < N; i++) begin
         plen += 1;
         if (bus.req[i]) begin
            ordq.push_back(i);
            plen += exp_glen(i);
         end
      end
      lenq.push_back(plen);
   endtask

   always @(posedge clk) cyc++;

   // Drawer models: granted drawers emit pixels and pulse done; others drive junk and stray dones.
   always @(negedge clk) begin : drawers
      logic [8:0]  x;
      logic [7:0]  y;
      logic [11:0] c;
      logic        we;
      logic        dn;
      for (int i = 0; i < N; i++) begin
         x  = 9'($urandom);
         y  = 8'($urandom);
         c  = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
         we = ($urandom_range(3) != 0);
         if (reset) begin
            gcyc[i] = 0;
            dn      = 1'b0;
         end else if (bus.grant[i]) begin
            if (dir_mode) begin
               c  = (gcyc[i] == 0) ? 12'h000 : 12'hFC0;
               we = 1'b1;
            end
            dn = !cfg_hang[i] && (gcyc[i] == cfg_len[i] - 1);
            if (we && !(bus.key_en[i] && c == 12'h000)) pxq.push_back('{x, y, c, cyc});
            gcyc[i]++;
         end else begin
            gcyc[i] = 0;
            dn      = ($urandom_range(9) == 0);
         end
         bus.px_x[9*i +: 9]      = x;
         bus.px_y[8*i +: 8]      = y;
         bus.px_color[CW*i +: CW] = c;
         bus.px_we[i]            = we;
         bus.done[i]             = dn;
      end
   end

   // Monitor: compares writes, grant order/length and pass length against the scoreboard.
   int gidx = -1;
   int glen = 0;
   int busy_cnt = 0;
   always @(negedge clk) begin : monitor
      px_t e;
      int  g;
      int  eo;
      if (reset) begin
         pxq.delete();
         ordq.delete();
         lenq.delete();
         gidx     = -1;
         glen     = 0;
         busy_cnt = 0;
      end else begin
         if (bus.writeEn) begin
            if (pxq.size() == 0) begin
               check("write_unexpected", bus.writeEn, 0);
            end else begin
               e = pxq.pop_front();
               check("px_x", bus.X_out, e.x);
               check("px_y", bus.Y_out, e.y);
               check("px_color", bus.Color_out, e.c);
               check("px_latency", cyc, e.t + 1);
            end
         end

         check("grant_onehot", $countones(bus.grant) <= 1, 1);
         g = -1;
         for (int i = 0; i < N; i++) if (bus.grant[i]) g = i;
         if (g >= 0) begin
            if (gidx < 0) begin
               if (ordq.size() == 0) begin
                  check("grant_unexpected", bus.grant, 0);
               end else begin
                  eo = ordq.pop_front();
                  check("grant_order", g, eo);
               end
               gidx = g;
               glen = 1;
            end else if (g == gidx) begin
               glen++;
            end else begin
               check("grant_no_gap", g, gidx);
               gidx = g;
               glen = 1;
            end
         end else if (gidx >= 0) begin
            check("grant_len", glen, exp_glen(gidx));
            gidx = -1;
         end

         if (bus.busy) busy_cnt++;
         if (bus.frame_done) begin
            fd_cnt++;
            check("frame_done_busy", bus.busy, 0);
            if (lenq.size() == 0) check("frame_done_unexpected", bus.frame_done, 0);
            else                  check("pass_len", busy_cnt, lenq.pop_front());
            check("pixels_left", pxq.size(), 0);
            busy_cnt = 0;
         end
      end
   end

   task automatic pulse_tick();
      @(negedge clk); #1;
      bus.frame_tick = 1'b1;
      @(negedge clk); #1;
      bus.frame_tick = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (fd_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_count", fd_cnt, target);
      repeat (4) @(negedge clk);
      check("frame_done_exact", fd_cnt, target);
      check("grants_left", ordq.size(), 0);
   endtask

   task automatic run_pass();
      int t0 = fd_cnt;
      push_pass();
      pulse_tick();
      wait_frames(t0 + 1);
   endtask

   task automatic set_lens(input int lo, input int hi);
      for (int i = 0; i < N; i++) begin
         cfg_len[i]  = $urandom_range(hi, lo);
         cfg_hang[i] = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int n;
      bus.frame_tick = 1'b0;
      bus.req        = '0;
      bus.key_en     = '0;
      set_lens(1, 1);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_grant", bus.grant, 0);
      check("rst_writeEn", bus.writeEn, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_timeout", bus.timeout_err, 0);
      check("rst_xyc", {bus.X_out, bus.Y_out, bus.Color_out}, 0);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      // All drawers, each done 10 cycles into its grant.
      bus.req = 6'b111111;
      for (int i = 0; i < N; i++) cfg_len[i] = 10;
      run_pass();

      // Only first and last slot request; middle slots are skipped.
      bus.req = 6'b100001;
      set_lens(1, 8);
      run_pass();

      // Randomised passes: requests, grant lengths, transparency.
      for (int k = 0; k < 10; k++) begin
         bus.req    = 6'($urandom);
         bus.key_en = 6'($urandom);
         set_lens(1, 20);
         run_pass();
      end

      // Colour key: drawer 1 transparent, drawer 0 opaque, both send 000 then FC0.
      bus.req    = 6'b000011;
      bus.key_en = 6'b000010;
      for (int i = 0; i < N; i++) cfg_len[i] = 2;
      dir_mode = 1'b1;
      run_pass();
      dir_mode = 1'b0;
      check("overrun_clear", bus.overrun, 0);
      check("timeout_clear", bus.timeout_err, 0);

      // Three ticks during a pass: one queued pass, overrun set.
      bus.req    = 6'b111111;
      bus.key_en = 6'($urandom);
      for (int i = 0; i < N; i++) cfg_len[i] = 10;
      t0 = fd_cnt;
      push_pass();
      push_pass();
      pulse_tick();
      repeat (3) @(negedge clk);
      repeat (3) pulse_tick();
      check("pending_busy", bus.busy, 1);
      wait_frames(t0 + 2);
      check("overrun_set", bus.overrun, 1);

      // Drawer 2 never finishes: watchdog releases it, drawer 3 follows.
      set_lens(2, 6);
      cfg_hang[2] = 1'b1;
      run_pass();
      check("timeout_set", bus.timeout_err, 1);
      cfg_hang[2] = 1'b0;

      // Reset in the middle of a grant.
      bus.req = 6'b111111;
      for (int i = 0; i < N; i++) cfg_len[i] = 10;
      push_pass();
      pulse_tick();
      n = 0;
      while (!bus.grant[2] && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reach_grant2", bus.grant[2], 1);
      #1 reset = 1'b1;
      @(negedge clk);
      check("mid_rst_grant", bus.grant, 0);
      check("mid_rst_writeEn", bus.writeEn, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_overrun", bus.overrun, 0);
      check("mid_rst_timeout", bus.timeout_err, 0);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", bus.busy, 0);
      bus.req = 6'b101101;
      set_lens(1, 6);
      run_pass();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
